// File: rtl/spi_flash_seq_if.sv
// Host request/completion and spi_flash command/response signals of the flash sequencer.
// The sequencer binds to the slave modport; the host plus flash side binds to master.
interface spi_flash_seq_if #(
    parameter int CMD_WD  = 8,
    parameter int ADDR_WD = 24,
    parameter int DATA_WD = 8,
    parameter int TOL_WD  = CMD_WD + ADDR_WD + DATA_WD
);
    logic [TOL_WD-1:0]  req_op;
    logic               req_vld;
    logic               req_rdy;
    logic               done_vld;
    logic               done_err;
    logic [DATA_WD-1:0] done_data;
    logic               busy;
    logic [TOL_WD-1:0]  flash_cmd;
    logic               flash_cmd_vld;
    logic               flash_cmd_rdy;
    logic               flash_rsp_vld;
    logic [DATA_WD-1:0] flash_rsp_data;

    modport slave (
        input  req_op,
        input  req_vld,
        output req_rdy,
        output done_vld,
        output done_err,
        output done_data,
        output busy,
        output flash_cmd,
        output flash_cmd_vld,
        input  flash_cmd_rdy,
        input  flash_rsp_vld,
        input  flash_rsp_data
    );

    modport master (
        output req_op,
        output req_vld,
        input  req_rdy,
        input  done_vld,
        input  done_err,
        input  done_data,
        input  busy,
        input  flash_cmd,
        input  flash_cmd_vld,
        output flash_cmd_rdy,
        output flash_rsp_vld,
        output flash_rsp_data
    );
endinterface

// File: rtl/spi_flash_seq.sv
// Command sequencer in front of spi_flash: power-up hold, read-class pass-through, and
// WREN + operation + RDSR polling for program/erase/write-status commands.
module spi_flash_seq #(
    parameter int CMD_WD    = 8,
    parameter int ADDR_WD   = 24,
    parameter int DATA_WD   = 8,
    parameter int TOL_WD    = CMD_WD + ADDR_WD + DATA_WD,
    parameter int PWRUP_CYC = 64516,
    parameter int POLL_GAP  = 16,
    parameter int MAX_POLLS = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_flash_seq_if.slave bus
);

    localparam logic [3:0] S_PWRUP      = 4'd0;
    localparam logic [3:0] S_IDLE       = 4'd1;
    localparam logic [3:0] S_WREN_ISSUE = 4'd2;
    localparam logic [3:0] S_WREN_WAIT  = 4'd3;
    localparam logic [3:0] S_OP_ISSUE   = 4'd4;
    localparam logic [3:0] S_OP_WAIT    = 4'd5;
    localparam logic [3:0] S_GAP        = 4'd6;
    localparam logic [3:0] S_POLL_ISSUE = 4'd7;
    localparam logic [3:0] S_POLL_WAIT  = 4'd8;
    localparam logic [3:0] S_DONE       = 4'd9;

    localparam int CNT_MAX = (PWRUP_CYC > POLL_GAP) ? PWRUP_CYC : POLL_GAP;
    localparam int CNT_WD  = $clog2(CNT_MAX + 1);
    localparam int POLL_WD = 16;

    localparam logic [TOL_WD-1:0] CMD_WREN = {CMD_WD'(8'h06), {(TOL_WD-CMD_WD){1'b0}}};
    localparam logic [TOL_WD-1:0] CMD_RDSR = {CMD_WD'(8'h05), {(TOL_WD-CMD_WD){1'b0}}};

    localparam logic [CNT_WD-1:0]  PWRUP_LAST = CNT_WD'(PWRUP_CYC - 1);
    localparam logic [CNT_WD-1:0]  GAP_LAST   = CNT_WD'(POLL_GAP - 1);
    localparam logic [POLL_WD-1:0] POLL_LIMIT = POLL_WD'(MAX_POLLS);

    // Opcodes that modify the array or status register and therefore need WREN and polling.
    function automatic logic is_write_class(input logic [CMD_WD-1:0] op);
        logic hit;
        case (op)
            CMD_WD'(8'h02), CMD_WD'(8'h38), CMD_WD'(8'h20), CMD_WD'(8'h52),
            CMD_WD'(8'hD8), CMD_WD'(8'h60), CMD_WD'(8'hC7), CMD_WD'(8'h01): hit = 1'b1;
            default:                                                          hit = 1'b0;
        endcase
        return hit;
    endfunction

    logic [3:0]         state;
    logic [CNT_WD-1:0]  wait_cnt;
    logic [POLL_WD-1:0] poll_cnt;
    logic [POLL_WD-1:0] poll_nxt;
    logic [TOL_WD-1:0]  req_q;
    logic               wr_q;
    logic [DATA_WD-1:0] rsp_q;
    logic               err_q;
    logic [TOL_WD-1:0]  cmd_q;
    logic               cmd_vld_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        poll_nxt = poll_cnt;
        if (poll_cnt != '1) begin
            poll_nxt = poll_cnt + 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, and every register is
    // cleared by the asynchronous reset so a mid-operation reset leaves nothing stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PWRUP;
            wait_cnt  <= '0;
            poll_cnt  <= '0;
            req_q     <= '0;
            wr_q      <= 1'b0;
            rsp_q     <= '0;
            err_q     <= 1'b0;
            cmd_q     <= '0;
            cmd_vld_q <= 1'b0;
        end else begin
            case (state)
                S_PWRUP: begin
                    if (wait_cnt == PWRUP_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_IDLE: begin
                    if (bus.req_vld) begin
                        req_q <= bus.req_op;
                        wr_q  <= is_write_class(bus.req_op[TOL_WD-1 -: CMD_WD]);
                        state <= is_write_class(bus.req_op[TOL_WD-1 -: CMD_WD]) ?
                                 S_WREN_ISSUE : S_OP_ISSUE;
                    end
                end

                // Issue states raise vld one cycle after entry and hold the command until accepted.
                S_WREN_ISSUE: begin
                    if (!cmd_vld_q) begin
                        cmd_vld_q <= 1'b1;
                        cmd_q     <= CMD_WREN;
                    end else if (bus.flash_cmd_rdy) begin
                        cmd_vld_q <= 1'b0;
                        state     <= S_WREN_WAIT;
                    end
                end

                S_WREN_WAIT: begin
                    if (bus.flash_rsp_vld) begin
                        state <= S_OP_ISSUE;
                    end
                end

                S_OP_ISSUE: begin
                    if (!cmd_vld_q) begin
                        cmd_vld_q <= 1'b1;
                        cmd_q     <= req_q;
                    end else if (bus.flash_cmd_rdy) begin
                        cmd_vld_q <= 1'b0;
                        state     <= S_OP_WAIT;
                    end
                end

                S_OP_WAIT: begin
                    if (bus.flash_rsp_vld) begin
                        rsp_q <= bus.flash_rsp_data;
                        err_q <= 1'b0;
                        if (wr_q) begin
                            poll_cnt <= '0;
                            wait_cnt <= '0;
                            state    <= S_GAP;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end

                S_GAP: begin
                    if (wait_cnt == GAP_LAST) begin
                        wait_cnt <= '0;
                        state    <= S_POLL_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_POLL_ISSUE: begin
                    if (!cmd_vld_q) begin
                        cmd_vld_q <= 1'b1;
                        cmd_q     <= CMD_RDSR;
                    end else if (bus.flash_cmd_rdy) begin
                        cmd_vld_q <= 1'b0;
                        state     <= S_POLL_WAIT;
                    end
                end

                // Timeout is judged on the count including the poll that just returned.
                S_POLL_WAIT: begin
                    if (bus.flash_rsp_vld) begin
                        rsp_q    <= bus.flash_rsp_data;
                        poll_cnt <= poll_nxt;
                        if (!bus.flash_rsp_data[0]) begin
                            err_q <= 1'b0;
                            state <= S_DONE;
                        end else if (poll_nxt == POLL_LIMIT) begin
                            err_q <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= S_GAP;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_PWRUP;
                end
            endcase
        end
    end

    assign bus.req_rdy       = (state == S_IDLE);
    assign bus.busy          = (state != S_IDLE);
    assign bus.done_vld      = (state == S_DONE);
    assign bus.done_err      = (state == S_DONE) && err_q;
    assign bus.done_data     = rsp_q;
    assign bus.flash_cmd     = cmd_q;
    assign bus.flash_cmd_vld = cmd_vld_q;

endmodule
